// File: rtl/agc_level_detector.sv
// Windowed peak-magnitude envelope detector feeding the AGC core.
// Emits one smoothed level per window: instant attack, shifted decay, plus a clip flag.
module agc_level_detector #(
  parameter int WIN_LOG2    = 6,
  parameter int DECAY_SHIFT = 3
) (
  input  logic              clk,
  input  logic              reset_x,
  input  logic signed [7:0] sample_in,
  input  logic              sample_valid,
  output logic [7:0]        level_out,
  output logic              level_valid,
  output logic              clip_flag,
  output logic [7:0]        peak_hold
);

  typedef enum logic {FILL, RUN} state_t;

  localparam logic [WIN_LOG2-1:0] CNT_ONE  = {{(WIN_LOG2-1){1'b0}}, 1'b1};
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  state_t              state_q, state_d;
  logic [WIN_LOG2-1:0] cnt_q;
  logic [7:0]          env_q;
  logic                clip_q;

  logic [7:0] mag_p0;
  logic       clip_p0;
  logic       close_p0;
  logic [7:0] wp_p0;
  logic [7:0] env_nxt_p0;

  // |x| with the single unrepresentable value 0x80 pinned to 127
  function automatic logic [7:0] sat_mag(input logic signed [7:0] s);
    logic signed [7:0] neg;
    neg = -s;
    if (!s[7])
      return $unsigned(s);
    else if (s[6:0] == 7'd0)
      return 8'd127;
    else
      return $unsigned(neg);
  endfunction

  // Step is at least 1, and never larger than env - wp, so env cannot drop below the peak
  function automatic logic [7:0] env_update(input logic [7:0] env, input logic [7:0] wp);
    logic [7:0] d;
    if (wp >= env)
      return wp;
    d = (env - wp) >> DECAY_SHIFT;
    if (d == 8'd0)
      d = 8'd1;
    return env - d;
  endfunction

  // Stage p0: combinational magnitude, window-close detect and envelope update
  always_comb begin
    mag_p0   = sat_mag(sample_in);
    clip_p0  = ($unsigned(sample_in) == 8'h7F) || ($unsigned(sample_in) == 8'h80);
    close_p0 = sample_valid && (cnt_q == CNT_LAST);
    wp_p0    = (mag_p0 > peak_hold) ? mag_p0 : peak_hold;
  end

  always_comb begin
    state_d    = state_q;
    env_nxt_p0 = wp_p0;
    if (state_q == RUN)
      env_nxt_p0 = env_update(env_q, wp_p0);
    if (close_p0)
      state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset_x)
      state_q <= FILL;
    else
      state_q <= state_d;
  end

  // Stage p1: registered window accumulators and per-window outputs
  always_ff @(posedge clk) begin
    if (reset_x) begin
      cnt_q       <= '0;
      env_q       <= 8'd0;
      clip_q      <= 1'b0;
      peak_hold   <= 8'd0;
      level_out   <= 8'd0;
      level_valid <= 1'b0;
      clip_flag   <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      if (sample_valid) begin
        cnt_q <= cnt_q + CNT_ONE;
        if (close_p0) begin
          env_q       <= env_nxt_p0;
          level_out   <= env_nxt_p0;
          clip_flag   <= clip_q | clip_p0;
          level_valid <= 1'b1;
          peak_hold   <= 8'd0;
          clip_q      <= 1'b0;
        end else begin
          peak_hold <= wp_p0;
          clip_q    <= clip_q | clip_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_agc_level_detector.sv
// Bench for agc_level_detector: directed scenarios plus randomized traffic
// compared every cycle against a window-list reference model.
module tb_agc_level_detector;

  localparam int WIN_LOG2    = 6;
  localparam int DECAY_SHIFT = 3;
  localparam int WIN         = 1 << WIN_LOG2;

  logic       clk = 1'b0;
  logic       reset_x = 1'b1;
  logic [7:0] sample_in = 8'd0;
  logic       sample_valid = 1'b0;
  logic [7:0] level_out;
  logic       level_valid;
  logic       clip_flag;
  logic [7:0] peak_hold;

  agc_level_detector #(.WIN_LOG2(WIN_LOG2), .DECAY_SHIFT(DECAY_SHIFT)) dut (
    .clk         (clk),
    .reset_x     (reset_x),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .level_out   (level_out),
    .level_valid (level_valid),
    .clip_flag   (clip_flag),
    .peak_hold   (peak_hold)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;

  // Reference model: the open window is kept as a list of magnitudes
  int   win_q[$];
  int   env_m   = 0;
  bit   fill_m  = 1'b1;
  bit   clipw_m = 1'b0;
  logic [7:0] exp_lo = 8'd0, exp_ph = 8'd0;
  logic [7:0] exp_lv = 8'd0, exp_clip = 8'd0;

  function automatic int mag_of(input logic [7:0] s);
    int v;
    v = $signed(s);
    if (v < 0) v = -v;
    if (v > 127) v = 127;
    return v;
  endfunction

  function automatic int list_max(input int q[$]);
    int m;
    m = 0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [7:0] s);
    int wp, d;
    if (r) begin
      win_q.delete();
      env_m = 0; fill_m = 1'b1; clipw_m = 1'b0;
      exp_lo = 8'd0; exp_lv = 8'd0; exp_clip = 8'd0; exp_ph = 8'd0;
      return;
    end
    exp_lv = 8'd0;
    if (v) begin
      win_q.push_back(mag_of(s));
      if (s == 8'h7F || s == 8'h80) clipw_m = 1'b1;
      if (win_q.size() == WIN) begin
        wp = list_max(win_q);
        if (fill_m || wp >= env_m) begin
          env_m = wp;
        end else begin
          d = (env_m - wp) / (1 << DECAY_SHIFT);
          if (d == 0) d = 1;
          env_m = env_m - d;
        end
        fill_m   = 1'b0;
        exp_lo   = 8'(env_m);
        exp_clip = {7'd0, clipw_m};
        exp_lv   = 8'd1;
        clipw_m  = 1'b0;
        win_q.delete();
      end
    end
    exp_ph = 8'(list_max(win_q));
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare all outputs
  task automatic step(input bit r, input bit v, input logic [7:0] s);
    reset_x = r; sample_valid = v; sample_in = s;
    @(posedge clk);
    model_edge(r, v, s);
    #1;
    if (level_valid === 1'b1) pulses++;
    chk("level_valid", {7'd0, level_valid}, exp_lv);
    chk("level_out", level_out, exp_lo);
    chk("clip_flag", {7'd0, clip_flag}, exp_clip);
    chk("peak_hold", peak_hold, exp_ph);
  endtask

  task automatic feed(input int n, input logic [7:0] s);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, s);
  endtask

  initial begin
    int p0;
    logic [7:0] rs;

    // Reset with random traffic present
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
    chk("rst_level_out", level_out, 8'd0);
    chk("rst_peak_hold", peak_hold, 8'd0);
    chk("rst_valid", {7'd0, level_valid}, 8'd0);

    // 63 samples must not close a window
    p0 = pulses;
    for (int i = 0; i < WIN - 1; i++) step(1'b0, 1'b1, 8'($urandom));
    chk("no_early_pulse", 8'(pulses - p0), 8'd0);

    // First window attack
    step(1'b1, 1'b0, 8'd0);
    feed(WIN - 1, 8'h40);
    chk("pre_close_peak", peak_hold, 8'd64);
    feed(1, 8'h40);
    chk("attack_valid", {7'd0, level_valid}, 8'd1);
    chk("attack_level", level_out, 8'd64);
    chk("attack_clip", {7'd0, clip_flag}, 8'd0);
    chk("attack_peak0", peak_hold, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    chk("pulse_one_cycle", {7'd0, level_valid}, 8'd0);
    chk("level_holds", level_out, 8'd64);

    // Clip via 0x80 as closing sample, then clean window decays from 127
    feed(WIN - 1, 8'h00);
    feed(1, 8'h80);
    chk("clip_level", level_out, 8'd127);
    chk("clip_flag_set", {7'd0, clip_flag}, 8'd1);
    feed(WIN, 8'h10);
    chk("clip_flag_clear", {7'd0, clip_flag}, 8'd0);
    chk("decay_from_127", level_out, 8'd114);

    // Decay by shifted difference
    step(1'b1, 1'b0, 8'd0);
    feed(WIN, 8'd100);
    feed(WIN, 8'd20);
    chk("decay_100_to_90", level_out, 8'd90);

    // Decay minimum step of 1
    step(1'b1, 1'b0, 8'd0);
    feed(WIN, 8'd21);
    feed(WIN, 8'd20);
    chk("decay_min_step", level_out, 8'd20);

    // Gapped valid: window closes on the 64th valid, not the 64th clock
    step(1'b1, 1'b0, 8'd0);
    p0 = pulses;
    for (int i = 0; i < 2 * WIN - 1; i++) step(1'b0, 1'(i % 2), 8'hF0);
    chk("gap_no_early", 8'(pulses - p0), 8'd0);
    step(1'b0, 1'b1, 8'hF0);
    chk("gap_valid", {7'd0, level_valid}, 8'd1);
    chk("gap_level", level_out, 8'd16);

    // Reset mid-window discards partial window and prior env
    feed(40, 8'h7F);
    step(1'b1, 1'b1, 8'h7F);
    feed(WIN, 8'h08);
    chk("midrst_level", level_out, 8'd8);
    chk("midrst_clip", {7'd0, clip_flag}, 8'd0);

    // Randomized traffic with occasional resets and extreme values
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0: rs = 8'h80;
        1: rs = 8'h7F;
        2: rs = 8'($urandom_range(0, 15));
        3: rs = 8'($urandom_range(240, 255));
        default: rs = 8'($urandom);
      endcase
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 7), rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
